cache_controller: RTL and testbench

CACHE_CONTROLLER -- requirements
Module: cache_controller

---
 rtl/cache_pkg.sv | 24 ++
 rtl/cache_mem.sv | 68 ++++++
 rtl/cache_controller.sv | 143 ++++++++++++++
 tb/tb_cache_controller.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared parameters, FSM encoding and block/word helpers for the
// 2-way set-associative write-through data cache.
package cache_pkg;

  localparam int          SETS_DEF      = 64;
  localparam int          TAG_W_DEF     = 10;
  localparam logic [31:0] BASE_ADDR_DEF = 32'd1024;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ_MISS = 2'd1,
    WRITE     = 2'd2
  } state_t;

  function automatic logic [31:0] word_of(input logic [63:0] block, input logic sel);
    return sel ? block[63:32] : block[31:0];
  endfunction

  function automatic logic [63:0] merge_word(input logic [63:0] block, input logic sel,
                                             input logic [31:0] word);
    return sel ? {word, block[31:0]} : {block[63:32], word};
  endfunction

endpackage

// File: rtl/cache_mem.sv
// Per-set storage: two ways of {valid, tag, 64-bit block} plus one LRU bit.
// Reads are combinational so the controller can resolve hits in the request cycle.
module cache_mem
  import cache_pkg::*;
#(
  parameter int SETS  = SETS_DEF,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(SETS)-1:0]  index,
  input  logic                     we,
  input  logic                     way_sel,
  input  logic [TAG_W-1:0]         wr_tag,
  input  logic [63:0]              wr_data,
  input  logic                     lru_we,
  input  logic                     lru_in,
  output logic [1:0]               rd_valid,
  output logic [2*TAG_W-1:0]       rd_tag,
  output logic [127:0]             rd_data,
  output logic                     rd_lru
);

  logic [SETS-1:0] lru_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_way
      logic [SETS-1:0]  valid_reg;
      logic [TAG_W-1:0] tag_mem  [SETS];
      logic [63:0]      data_mem [SETS];
      logic             way_we;

      assign way_we = we && (way_sel == 1'(gi));

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          valid_reg <= '0;
        end else if (way_we) begin
          valid_reg[index] <= 1'b1;
        end
      end

      // Tag/data carry no reset: their contents only matter behind a valid bit.
      always_ff @(posedge clk) begin
        if (way_we) begin
          tag_mem[index]  <= wr_tag;
          data_mem[index] <= wr_data;
        end
      end

      assign rd_valid[gi]                 = valid_reg[index];
      assign rd_tag[gi*TAG_W +: TAG_W]    = tag_mem[index];
      assign rd_data[gi*64 +: 64]         = data_mem[index];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lru_reg <= '0;
    end else if (lru_we) begin
      lru_reg[index] <= lru_in;
    end
  end

  assign rd_lru = lru_reg[index];

endmodule

// File: rtl/cache_controller.sv
// Write-through, no-write-allocate 2-way data cache between the MEM stage
// and an SRAM controller that returns 64-bit blocks.
module cache_controller
  import cache_pkg::*;
#(
  parameter int          SETS      = SETS_DEF,
  parameter int          TAG_W     = TAG_W_DEF,
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        sram_rd_en,
  output logic        sram_wr_en,
  output logic [31:0] sram_address,
  output logic [31:0] sram_write_data,
  input  logic [63:0] sram_read_data,
  input  logic        sram_ready
);

  localparam int IDX_W = $clog2(SETS);

  state_t state_reg, state_next;

  logic [31:0]      offset;
  logic             word_sel;
  logic [IDX_W-1:0] index;
  logic [TAG_W-1:0] tag;

  assign offset   = address - BASE_ADDR;
  assign word_sel = offset[2];
  assign index    = offset[3 +: IDX_W];
  assign tag      = offset[3+IDX_W +: TAG_W];

  logic [1:0]         rd_valid;
  logic [2*TAG_W-1:0] rd_tag;
  logic [127:0]       rd_data;
  logic               rd_lru;
  logic               mem_we, mem_way, lru_we, lru_in;
  logic [63:0]        mem_data;

  cache_mem #(.SETS(SETS), .TAG_W(TAG_W)) u_mem (
    .clk      (clk),
    .rst      (rst),
    .index    (index),
    .we       (mem_we),
    .way_sel  (mem_way),
    .wr_tag   (tag),
    .wr_data  (mem_data),
    .lru_we   (lru_we),
    .lru_in   (lru_in),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .rd_lru   (rd_lru)
  );

  logic        hit0, hit1, hit, hit_way, victim;
  logic [63:0] hit_block;

  // Way 0 takes priority so a corrupted duplicate can never produce two hits.
  assign hit0      = rd_valid[0] && (rd_tag[0 +: TAG_W] == tag);
  assign hit1      = rd_valid[1] && (rd_tag[TAG_W +: TAG_W] == tag) && !hit0;
  assign hit       = hit0 || hit1;
  assign hit_way   = hit1;
  assign hit_block = hit_way ? rd_data[127:64] : rd_data[63:0];
  assign victim    = !rd_valid[0] ? 1'b0 : (!rd_valid[1] ? 1'b1 : rd_lru);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ready      = 1'b0;
    read_data  = '0;
    sram_rd_en = 1'b0;
    sram_wr_en = 1'b0;
    mem_we     = 1'b0;
    mem_way    = 1'b0;
    mem_data   = sram_read_data;
    lru_we     = 1'b0;
    lru_in     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (wr_en) begin
          state_next = WRITE;
        end else if (rd_en) begin
          if (hit) begin
            ready     = 1'b1;
            read_data = word_of(hit_block, word_sel);
            lru_we    = 1'b1;
            lru_in    = ~hit_way;
          end else begin
            state_next = READ_MISS;
          end
        end else begin
          ready = 1'b1;
        end
      end
      READ_MISS: begin
        sram_rd_en = 1'b1;
        if (sram_ready) begin
          ready      = 1'b1;
          read_data  = word_of(sram_read_data, word_sel);
          mem_we     = 1'b1;
          mem_way    = victim;
          lru_we     = 1'b1;
          lru_in     = ~victim;
          state_next = IDLE;
        end
      end
      WRITE: begin
        sram_wr_en = 1'b1;
        if (sram_ready) begin
          ready      = 1'b1;
          state_next = IDLE;
          if (hit) begin
            mem_we   = 1'b1;
            mem_way  = hit_way;
            mem_data = merge_word(hit_block, word_sel, write_data);
            lru_we   = 1'b1;
            lru_in   = ~hit_way;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign sram_address    = address;
  assign sram_write_data = write_data;

endmodule

// File: tb/tb_cache_controller.sv
// Scoreboard bench: driver pushes expectations from a set/way reference model,
// monitor pops and compares whenever a request completes.
module tb_cache_controller;

  logic        clk, rst;
  logic        rd_en, wr_en;
  logic [31:0] address, write_data, read_data;
  logic        ready, sram_rd_en, sram_wr_en;
  logic [31:0] sram_address, sram_write_data;
  logic [63:0] sram_read_data;
  logic        sram_ready;

  cache_controller #(.SETS(64), .TAG_W(10), .BASE_ADDR(32'd1024)) dut (
    .clk             (clk),
    .rst             (rst),
    .rd_en           (rd_en),
    .wr_en           (wr_en),
    .address         (address),
    .write_data      (write_data),
    .read_data       (read_data),
    .ready           (ready),
    .sram_rd_en      (sram_rd_en),
    .sram_wr_en      (sram_wr_en),
    .sram_address    (sram_address),
    .sram_write_data (sram_write_data),
    .sram_read_data  (sram_read_data),
    .sram_ready      (sram_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    bit          sram_rd;
    bit          sram_wr;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: each set is two {valid, tag, block} entries plus an LRU flag.
  bit          mv   [64][2];
  int unsigned mt   [64][2];
  logic [63:0] md   [64][2];
  bit          mlru [64];

  task automatic model_reset();
    for (int s = 0; s < 64; s++) begin
      mv[s][0] = 0; mv[s][1] = 0; mlru[s] = 0;
    end
  endtask

  task automatic model_access(input bit rd, input bit wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [63:0] block,
                              output exp_t e);
    int unsigned off, w, idx, tg;
    int h, v;
    off = addr - 32'd1024;
    w   = (off / 4) % 2;
    idx = (off / 8) % 64;
    tg  = (off / 512) % 1024;
    h = -1;
    for (int k = 0; k < 2; k++) if (mv[idx][k] && mt[idx][k] == tg) h = k;
    e.data = 0; e.sram_rd = 0; e.sram_wr = 0;
    if (wr) begin
      e.sram_wr = 1;
      if (h >= 0) begin
        if (w == 1) md[idx][h][63:32] = wdata;
        else        md[idx][h][31:0]  = wdata;
        mlru[idx] = (h == 0);
      end
    end else if (rd) begin
      if (h >= 0) begin
        e.data = (w == 1) ? md[idx][h][63:32] : md[idx][h][31:0];
        mlru[idx] = (h == 0);
      end else begin
        e.sram_rd = 1;
        e.data = (w == 1) ? block[63:32] : block[31:0];
        if (!mv[idx][0])      v = 0;
        else if (!mv[idx][1]) v = 1;
        else                  v = mlru[idx] ? 1 : 0;
        mv[idx][v] = 1; mt[idx][v] = tg; md[idx][v] = block;
        mlru[idx] = (v == 0);
      end
    end
  endtask

  task automatic do_txn(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [63:0] block);
    exp_t e;
    int dly, cyc;
    bit done;
    model_access(rd, wr, addr, wdata, block, e);
    q.push_back(e);
    @(posedge clk); #1;
    rd_en = rd; wr_en = wr; address = addr; write_data = wdata;
    sram_read_data = block; sram_ready = 1'b0;
    dly = $urandom_range(0, 3); cyc = 0; done = 0;
    while (!done) begin
      @(negedge clk);
      if (ready) done = 1;
      else if (cyc >= 20) begin
        n_checks++; n_fail++;
        $display("FAIL timeout addr=%h actual=no_ready required=ready", addr);
        done = 1;
      end else begin
        @(posedge clk); #1;
        sram_ready = (cyc == dly);
        cyc++;
      end
    end
    @(posedge clk); #1;
    rd_en = 0; wr_en = 0; sram_ready = 0;
    sram_read_data = {$urandom, $urandom};
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rd_en = 0; wr_en = 0;
      sram_ready = ($urandom_range(0, 3) == 0);
      sram_read_data = {$urandom, $urandom};
    end
    @(posedge clk); #1;
    sram_ready = 0;
  endtask

  // Monitor: checks idle behaviour, stall outputs and completions.
  bit saw_rd, saw_wr;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      saw_rd = 0; saw_wr = 0;
    end else if (rd_en || wr_en) begin
      chk("sram_excl", 64'(sram_rd_en & sram_wr_en), 64'd0);
      saw_rd |= sram_rd_en;
      saw_wr |= sram_wr_en;
      if (ready) begin
        if (q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_completion actual=ready required=no_txn");
        end else begin
          e = q.pop_front();
          chk("read_data", 64'(read_data), 64'(e.data));
          chk("sram_rd_used", 64'(saw_rd), 64'(e.sram_rd));
          chk("sram_wr_used", 64'(saw_wr), 64'(e.sram_wr));
          chk("sram_address", 64'(sram_address), 64'(address));
          chk("sram_wdata", 64'(sram_write_data), 64'(write_data));
          $display("txn rd=%0b wr=%0b addr=%h wdata=%h rdata=%h sram_rd=%0b sram_wr=%0b",
                   rd_en, wr_en, address, write_data, read_data, saw_rd, saw_wr);
        end
        saw_rd = 0; saw_wr = 0;
      end else begin
        chk("stall_rdata", 64'(read_data), 64'd0);
      end
    end else begin
      chk("idle", {29'd0, ready, sram_rd_en, sram_wr_en, read_data},
                  {29'd0, 1'b1, 1'b0, 1'b0, 32'd0});
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r;
    logic [31:0] a;
    rst = 0; rd_en = 0; wr_en = 0; address = 0; write_data = 0;
    sram_read_data = 0; sram_ready = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {61'd0, ready, sram_rd_en, sram_wr_en}, {61'd0, 1'b1, 1'b0, 1'b0});
    rst = 1;
    idle(2);

    // Cold miss, then hit on the other word of the same block.
    do_txn(1, 0, 32'h400, 32'h0, 64'h11112222_33334444);
    do_txn(1, 0, 32'h404, 32'h0, 64'hAAAA_AAAA_AAAA_AAAA);
    // Three tags in set 0: 0x1400 evicts the 0x400 way.
    do_txn(1, 0, 32'hC00,  32'h0, 64'h5555_6666_7777_8888);
    do_txn(1, 0, 32'h1400, 32'h0, 64'h9999_AAAA_BBBB_CCCC);
    do_txn(1, 0, 32'hC00,  32'h0, 64'hDEAD_0000_DEAD_0000);
    do_txn(1, 0, 32'h400,  32'h0, 64'h11112222_33334444);
    // Write-through hit updates the cached word; write miss does not allocate.
    do_txn(0, 1, 32'h404, 32'hDEADBEEF, 64'h0);
    do_txn(1, 0, 32'h404, 32'h0, 64'h0123_4567_89AB_CDEF);
    do_txn(0, 1, 32'h800, 32'hCAFEF00D, 64'h0);
    do_txn(1, 0, 32'h800, 32'h0, 64'h0F0F_0F0F_F0F0_F0F0);
    // Simultaneous rd_en/wr_en takes the write path.
    do_txn(1, 1, 32'h400, 32'h12345678, 64'h0);
    do_txn(1, 0, 32'h400, 32'h0, 64'hFFFF_FFFF_FFFF_FFFF);
    idle(3);

    // Reset in the middle of a read miss.
    @(posedge clk); #1;
    rd_en = 1; address = 32'h2400; sram_read_data = 64'h0BAD_0BAD_0BAD_0BAD;
    repeat (2) @(negedge clk);
    chk("miss_rd_en", 64'(sram_rd_en), 64'd1);
    #2 rst = 0;
    #1 chk("rst_rd_en", 64'(sram_rd_en), 64'd0);
    rd_en = 0;
    model_reset();
    @(posedge clk); #1 rst = 1;
    idle(2);
    do_txn(1, 0, 32'h400, 32'h0, 64'h2222_1111_4444_3333);
    do_txn(1, 0, 32'h2400, 32'h0, 64'h7777_7777_6666_6666);

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      a = 32'd1024 + $urandom_range(0, 3) * 512 + $urandom_range(0, 2) * 8
        + $urandom_range(0, 1) * 4 + $urandom_range(0, 3);
      do_txn(r < 6 || r == 9, r >= 6, a, $urandom, {$urandom, $urandom});
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 2));
    end

    idle(3);
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
